// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed low-active 7-segment bus: debounces each digit,
// decodes glyphs back to hex and assembles frames. Optional macro: SEG7_BLANK_ACCEPT_EN.
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_sel_n,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  value_valid,
  output logic                  frame_done
`ifdef SEG7_BLANK_ACCEPT_EN
  ,
  output logic [DIGITS-1:0]     blank_mask
`endif
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  // Returns {legal, nibble}; anything not in the glyph set is illegal.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h10:   decode = 5'h19;
      7'h08:   decode = 5'h1A;
      7'h03:   decode = 5'h1B;
      7'h46:   decode = 5'h1C;
      7'h21:   decode = 5'h1D;
      7'h06:   decode = 5'h1E;
      7'h0E:   decode = 5'h1F;
`ifdef SEG7_BLANK_ACCEPT_EN
      7'h7F:   decode = 5'h10;
`endif
      default: decode = 5'h00;
    endcase
  endfunction

  state_t          state, state_next;
  logic [IW-1:0]   cand_idx, cand_idx_next;
  logic [6:0]      cand_seg, cand_seg_next;
  logic [7:0]      cnt, cnt_next;
  logic [3:0]      sel_count;
  logic [IW-1:0]   sel_idx;
  logic            sel_valid;
  logic            match;
  logic            commit;

  logic [4*DIGITS-1:0] value_next;
  logic [DIGITS-1:0]   err_next;
  logic [DIGITS-1:0]   seen, seen_next;
  logic                valid_next;
  logic                done_next;
  logic [4:0]          dec;
`ifdef SEG7_BLANK_ACCEPT_EN
  logic [DIGITS-1:0]   blank_next;
`endif

  // Zero or several active enables both mean "nothing selected".
  always_comb begin
    sel_count = '0;
    sel_idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!dig_sel_n[i]) begin
        sel_count = sel_count + 4'd1;
        sel_idx   = IW'(i);
      end
    end
    sel_valid = (sel_count == 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cand_idx <= '0;
      cand_seg <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_next;
      cand_idx <= cand_idx_next;
      cand_seg <= cand_seg_next;
      cnt      <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    cand_idx_next = cand_idx;
    cand_seg_next = cand_seg;
    cnt_next      = cnt;
    commit        = 1'b0;
    match         = sel_valid && (sel_idx == cand_idx) && (seg_n == cand_seg);
    case (state)
      IDLE: begin
        if (sel_valid) begin
          cand_idx_next = sel_idx;
          cand_seg_next = seg_n;
          cnt_next      = 8'd1;
          state_next    = TRACK;
        end
      end
      TRACK: begin
        if (!sel_valid) begin
          state_next = IDLE;
        end else if (match) begin
          cnt_next = cnt + 8'd1;
          if (cnt == LAST) begin
            commit     = 1'b1;
            state_next = LOCKED;
          end
        end else begin
          cand_idx_next = sel_idx;
          cand_seg_next = seg_n;
          cnt_next      = 8'd1;
        end
      end
      LOCKED: begin
        if (!sel_valid) begin
          state_next = IDLE;
        end else if (!match) begin
          cand_idx_next = sel_idx;
          cand_seg_next = seg_n;
          cnt_next      = 8'd1;
          state_next    = TRACK;
        end
      end
      default: state_next = IDLE;
    endcase
    if (clear) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  // Frame evaluation looks at the error state that already includes this cycle's commit.
  always_comb begin
    value_next = value;
    err_next   = digit_err;
    seen_next  = seen;
    valid_next = value_valid;
    done_next  = 1'b0;
    dec        = decode(cand_seg);
`ifdef SEG7_BLANK_ACCEPT_EN
    blank_next = blank_mask;
`endif
    if (commit) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (IW'(i) == cand_idx) begin
          if (dec[4]) begin
            value_next[4*i +: 4] = dec[3:0];
            err_next[i]          = 1'b0;
          end else begin
            err_next[i]          = 1'b1;
          end
          seen_next[i] = 1'b1;
`ifdef SEG7_BLANK_ACCEPT_EN
          blank_next[i] = (cand_seg == 7'h7F);
`endif
        end
      end
    end
    if (&seen_next) begin
      done_next  = 1'b1;
      valid_next = (err_next == '0);
      seen_next  = '0;
    end
    if (clear) begin
      value_next = '0;
      err_next   = '0;
      seen_next  = '0;
      valid_next = 1'b0;
      done_next  = 1'b0;
`ifdef SEG7_BLANK_ACCEPT_EN
      blank_next = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      digit_err   <= '0;
      seen        <= '0;
      value_valid <= 1'b0;
      frame_done  <= 1'b0;
`ifdef SEG7_BLANK_ACCEPT_EN
      blank_mask  <= '0;
`endif
    end else begin
      value       <= value_next;
      digit_err   <= err_next;
      seen        <= seen_next;
      value_valid <= valid_next;
      frame_done  <= done_next;
`ifdef SEG7_BLANK_ACCEPT_EN
      blank_mask  <= blank_next;
`endif
    end
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receiving end of the low-active 7-segment interface.
- Monitors a time-multiplexed display bus (segments plus digit enables), waits for each digit's pattern to be stable, and inverts the 7-segment encoding back to 4-bit hex.
- Assembles a full multi-digit value and flags any digit whose pattern is not a legal hex glyph.
- Sits between the display driver and self-check or readback logic; used for on-board loopback of display outputs.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is committed (2..255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seg_n  input  7  segment bus, low-active, bit 0 = top, 1 = upper-right, 2 = lower-right, 3 = bottom, 4 = lower-left, 5 = upper-left, 6 = middle.
- dig_sel_n  input  DIGITS  digit enables, low-active, one-hot when driven.
- clear  input  1  synchronous clear of all captured state.
- value  output  4*DIGITS  captured hex value, digit k in bits [4k+3:4k].
- digit_err  output  DIGITS  digit k last committed an illegal pattern.
- value_valid  output  1  high after a complete frame with no errors.
- frame_done  output  1  one-cycle pulse when every digit has been committed since the last frame.

Behaviour:
- Reset (rst_n low, asynchronous): value=0, digit_err=0, value_valid=0, frame_done=0, seen mask=0, FSM=IDLE, stability counter=0.
- Select decode: exactly one zero bit in dig_sel_n gives active index k. Zero or multiple zero bits mean "no select".
- Decode table (seg_n to nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F (hex, 7-bit). Every other pattern, including 7F (blank), is illegal.
- FSM IDLE: on a valid select, latch (k, seg_n) as candidate, set counter=1, go to TRACK.
- FSM TRACK: each cycle compare (k, seg_n) with the candidate.
  - Match: counter++. When counter reaches STABLE_CYCLES, commit and go to LOCKED.
  - Mismatch with a valid select: reload the candidate, counter=1, stay in TRACK.
  - No select: go to IDLE.
- FSM LOCKED: stay while (k, seg_n) equals the candidate, with no further commits. A change with a valid select reloads the candidate (counter=1, TRACK). No select goes to IDLE.
- Commit latency: the commit takes effect on the clock edge at which the STABLE_CYCLES-th matching sample is taken; outputs update the following cycle.
- Commit, legal pattern: value nibble k = decoded value, digit_err[k]=0, seen[k]=1.
- Commit, illegal pattern: nibble k unchanged, digit_err[k]=1, seen[k]=1.
- Frame completion: in the cycle after seen becomes all ones:
  - frame_done=1 for exactly one cycle.
  - value_valid = (digit_err==0), held until the next frame completion or clear.
  - seen cleared to 0.
- A digit re-committed before the frame completes simply overwrites its nibble and error bit.
- Simultaneous commit and frame completion: the frame evaluation uses the error state that includes the commit completing the frame.
- clear (synchronous) has priority over commit. Next cycle: value=0, digit_err=0, value_valid=0, seen=0, FSM=IDLE, frame_done=0.
- Reset mid-frame discards partial capture. No output glitches; all outputs are registered.

Optional Feature:
- Macro SEG7_BLANK_ACCEPT_EN.
- Defined:
  - Pattern 7F is legal and decodes to nibble 0 with digit_err[k]=0.
  - An extra output port blank_mask [DIGITS] sets bit k on a blank commit and clears it on any other commit.
  - blank_mask resets and clears to 0.
- Undefined: 7F is illegal like any other non-glyph, and port blank_mask does not exist.

Test Plan:
- Drive digits 0..3 in turn with patterns 30, 02, 46, 40 (hex), each held 6 cycles -> value=16'h0C63, digit_err=0, one frame_done pulse, value_valid=1.
- Hold digit 2 with seg_n=7'h7F for 6 cycles within a full frame; other digits legal -> digit_err[2]=1, nibble 2 unchanged, value_valid=0 on frame_done. With SEG7_BLANK_ACCEPT_EN defined -> nibble 2=0, blank_mask[2]=1, value_valid=1.
- Digit 1 pattern 79 held STABLE_CYCLES-1 cycles, then switched to 24 for STABLE_CYCLES cycles -> only 2 committed to nibble 1; no commit of 1.
- dig_sel_n=4'b1100 (two active) for 10 cycles -> no commit; FSM in IDLE; outputs unchanged.
- Pattern held 50 cycles in LOCKED -> exactly one commit. Assert clear mid-frame -> next cycle value=0, seen=0, no frame_done.
- Assert rst_n low asynchronously mid-TRACK -> all outputs 0 immediately. After release, a full frame of 0E,0E,0E,0E -> value=16'hFFFF, value_valid=1.
